// File: rtl/ps2_key_event_rx_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key event receiver.
//   PS2_EXT_PREFIX / PS2_BRK_PREFIX : scan-code prefix bytes (E0 / F0)
//   ps2_dec_state_t                 : prefix-folding decoder states
//   ps2_evt_t                       : folded key event {ext, brk, code}
//   frame_ok()                      : start/odd-parity/stop check of an 11-bit frame
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        D_IDLE,
        D_EXT,
        D_BRK,
        D_EXT_BRK
    } ps2_dec_state_t;

    // brk is the F0 (release) marker; 'release' itself is a reserved word.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Frame bit 0 is the start bit; bits 1..8 data LSB first; bit 9 parity; bit 10 stop.
    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (^f[9:1] == 1'b1) && (f[10] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_key_event_rx_if.sv
// ps2_key_event_rx_if: valid/ready key event stream.
//   evt_valid   : head event available (producer)
//   evt_ready   : consumer accepts head event
//   evt_code    : scan code of head event
//   evt_ext     : head event had E0 prefix
//   evt_release : head event had F0 prefix
// master = event producer (receiver), slave = event consumer.
interface ps2_key_event_rx_if;
    import ps2_pkg::*;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;

    modport master (output evt_valid, output evt_code, output evt_ext,
                    output evt_release, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_ext,
                    input evt_release, output evt_ready);
endinterface

// File: rtl/ps2_key_event_rx_fifo.sv
// ps2_evt_fifo: synchronous FIFO of ps2_evt_t with a registered show-ahead head.
//   clock, resetn : clock, async active-low reset
//   push, wdata   : write request and event
//   pop           : consume head (ignored when empty)
//   head, valid   : registered head event and non-empty flag
//   level         : registered occupancy
//   full_c        : occupancy equals DEPTH (combinational)
//   accept_c      : this cycle's push is stored (combinational)
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  ps2_evt_t         wdata,
    input  logic             pop,
    output ps2_evt_t         head,
    output logic             valid,
    output logic [LVL_W-1:0] level,
    output logic             full_c,
    output logic             accept_c
);

    ps2_evt_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic             pop_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok    = pop && valid;
    assign full_c    = (level == LVL_W'(DEPTH));
    assign accept_c  = push && (!full_c || pop_ok);
    assign rd_nxt    = rd_ptr + PTR_W'(1);
    assign level_nxt = level + LVL_W'(accept_c) - LVL_W'(pop_ok);

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            if (accept_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)   rd_ptr <= rd_nxt;
            level <= level_nxt;
            valid <= (level_nxt != '0);
            // Head takes the incoming word when it becomes the only entry,
            // otherwise the next stored entry after a pop.
            if (accept_c && ((level == '0) || (pop_ok && level == LVL_W'(1))))
                head <= wdata;
            else if (pop_ok && level >= LVL_W'(2))
                head <= mem[rd_nxt];
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (accept_c) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver folding E0/F0 prefixes into key events.
//   clock, resetn : system clock, async active-low reset
//   ps2_clk/data  : raw PS/2 pins (synchronised internally)
//   evt           : key event stream (master modport)
//   press_count   : make events stored, wraps
//   fifo_level    : occupied event FIFO entries
//   overflow      : sticky, event dropped on full FIFO
//   frame_err     : sticky, start/parity/stop error
//   clr_flags     : synchronous clear of overflow and frame_err
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of the held key.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH     = 8,
    parameter  int unsigned CNT_W          = 8,
    parameter  int unsigned SYNC_STAGES    = 2,
    parameter  int unsigned TIMEOUT_CYCLES = 50000,
    localparam int unsigned LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    ps2_key_event_rx_if.master  evt,
    output logic [CNT_W-1:0]    press_count,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                overflow,
    output logic                frame_err,
    input  logic                clr_flags
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_c;

    logic [3:0]             bit_cnt;
    logic [9:0]             shift;
    logic [10:0]            frame_c;
    logic [IDLE_W-1:0]      idle_cnt;
    logic                   timeout_c;
    logic                   frame_bad_c;
    logic                   byte_valid;
    logic [7:0]             rx_byte;

    ps2_dec_state_t         state;
    ps2_dec_state_t         state_nxt;
    ps2_evt_t               dec_evt_c;
    logic                   emit_c;
    logic                   suppress_c;
    logic                   push_c;

    ps2_evt_t               head;
    logic                   fifo_valid;
    logic                   full_c;
    logic                   accept_c;
    logic                   pop_c;

    // Pin synchronisers, idle-high so reset never fakes a falling edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s       = clk_sync[SYNC_STAGES-1];
    assign data_s      = data_sync[SYNC_STAGES-1];
    assign fall_c      = clk_prev && !clk_s;
    // Bits arrive LSB first, so the newest sample enters at the top.
    assign frame_c     = {data_s, shift};
    assign timeout_c   = (bit_cnt != 4'd0) && (idle_cnt == IDLE_MAX);
    assign frame_bad_c = fall_c && (bit_cnt == 4'd10) && !frame_ok(frame_c);

    // Frame receiver with idle timeout on partial frames.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bit_cnt    <= 4'd0;
            shift      <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'h00;
        end else begin
            byte_valid <= 1'b0;
            if (fall_c) begin
                idle_cnt <= '0;
                shift    <= frame_c[10:1];
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok(frame_c)) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= frame_c[8:1];
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);
                if (timeout_c) bit_cnt <= 4'd0;
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= D_IDLE;
        else         state <= state_nxt;
    end

    // Decoder next state: prefixes accumulate, any other byte ends the sequence.
    always_comb begin
        state_nxt = state;
        if (byte_valid) begin
            unique case (state)
                D_IDLE: begin
                    if (rx_byte == PS2_EXT_PREFIX)      state_nxt = D_EXT;
                    else if (rx_byte == PS2_BRK_PREFIX) state_nxt = D_BRK;
                end
                D_EXT: begin
                    if (rx_byte == PS2_BRK_PREFIX)      state_nxt = D_EXT_BRK;
                    else if (rx_byte != PS2_EXT_PREFIX) state_nxt = D_IDLE;
                end
                D_BRK, D_EXT_BRK: begin
                    if (rx_byte != PS2_EXT_PREFIX && rx_byte != PS2_BRK_PREFIX)
                        state_nxt = D_IDLE;
                end
                default: state_nxt = D_IDLE;
            endcase
        end
    end

    // Decoder outputs: event fields follow the prefixes collected so far.
    always_comb begin
        emit_c         = 1'b0;
        dec_evt_c      = '0;
        dec_evt_c.ext  = (state == D_EXT) || (state == D_EXT_BRK);
        dec_evt_c.brk  = (state == D_BRK) || (state == D_EXT_BRK);
        dec_evt_c.code = rx_byte;
        if (byte_valid && rx_byte != PS2_EXT_PREFIX && rx_byte != PS2_BRK_PREFIX)
            emit_c = 1'b1;
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid;
    logic       held_ext;
    logic [7:0] held_code;
    logic       held_match_c;

    assign held_match_c = held_valid && (held_ext == dec_evt_c.ext)
                       && (held_code == dec_evt_c.code);
    assign suppress_c   = !dec_evt_c.brk && held_match_c;

    // Track the single most recent held key; its break releases it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
        end else if (emit_c) begin
            if (!dec_evt_c.brk) begin
                held_valid <= 1'b1;
                held_ext   <= dec_evt_c.ext;
                held_code  <= dec_evt_c.code;
            end else if (held_match_c) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign suppress_c = 1'b0;
`endif

    assign push_c = emit_c && !suppress_c;
    assign pop_c  = fifo_valid && evt.evt_ready;

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (push_c),
        .wdata    (dec_evt_c),
        .pop      (pop_c),
        .head     (head),
        .valid    (fifo_valid),
        .level    (fifo_level),
        .full_c   (full_c),
        .accept_c (accept_c)
    );

    assign evt.evt_valid   = fifo_valid;
    assign evt.evt_code    = head.code;
    assign evt.evt_ext     = head.ext;
    assign evt.evt_release = head.brk;

    // Press counter and sticky flags; clear wins over a same-cycle set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            press_count <= '0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (accept_c && !dec_evt_c.brk) press_count <= press_count + CNT_W'(1);
            if (clr_flags) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                if (push_c && full_c && !pop_c) overflow <= 1'b1;
                if (frame_bad_c)                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
`timescale 1ns/1ps
module tb_ps2_key_event_rx;
    import ps2_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO   = 300;
    localparam int unsigned HALF  = 8;

    logic             clock     = 1'b0;
    logic             resetn    = 1'b0;
    logic             ps2_clk   = 1'b1;
    logic             ps2_data  = 1'b1;
    logic             clr_flags = 1'b0;
    logic [CNT_W-1:0] press_count;
    logic [2:0]       fifo_level;
    logic             overflow;
    logic             frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_press   = 0;
    int last_lat    = -1;
    logic [9:0] sb[$];
    logic [9:0] exp_e;
    logic [9:0] got_e;

    ps2_key_event_rx_if evt_if();

    ps2_key_event_rx #(
        .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt(evt_if), .press_count(press_count), .fifo_level(fifo_level),
        .overflow(overflow), .frame_err(frame_err), .clr_flags(clr_flags)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // One clock step; every accepted event is checked against the scoreboard.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (resetn && evt_if.evt_valid && evt_if.evt_ready) begin
                vectors++;
                got_e = {evt_if.evt_ext, evt_if.evt_release, evt_if.evt_code};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL evt_unexpected: got %h, required no event", got_e);
                end else begin
                    exp_e = sb.pop_front();
                    if (got_e !== exp_e) begin
                        miscompares++;
                        $display("FAIL evt_match: got %h, required %h", got_e, exp_e);
                    end
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            ps2_clk  = 1'b1;
            tick(HALF);
            ps2_clk  = 1'b0;
            last_lat = -1;
            for (int k = 1; k <= int'(HALF); k++) begin
                tick(1);
                if (evt_if.evt_valid && last_lat < 0) last_lat = k;
            end
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || evt_if.evt_valid) && n < 400) begin
            tick(1);
            n++;
        end
        vectors++;
        if (n >= 400) begin
            miscompares++;
            $display("FAIL %s_drain: %0d events outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic check_press(input string name);
        vectors++;
        if (press_count !== CNT_W'(exp_press)) begin
            miscompares++;
            $display("FAIL %s_press: got %0d, required %0d", name, press_count, exp_press);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        evt_if.evt_ready = 1'b1;
        tick(3);
        vectors++;
        if ({evt_if.evt_valid, press_count, fifo_level, overflow, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b cnt=%0d lvl=%0d ovf=%b ferr=%b, required all 0",
                     evt_if.evt_valid, press_count, fifo_level, overflow, frame_err);
        end
        resetn = 1'b1;
        tick(3);
    endtask

    task automatic test_make();
        sb.push_back({2'b00, 8'h1C});
        exp_press++;
        send_byte(8'h1C);
        wait_drain("make");
        vectors++;
        if (last_lat !== 4) begin
            miscompares++;
            $display("FAIL make_latency: got %0d cycles, required 4", last_lat);
        end
        check_press("make");
    endtask

    task automatic test_break();
        sb.push_back({2'b01, 8'h1C});
        send_byte(8'hF0);
        send_byte(8'h1C);
        wait_drain("break");
        check_press("break");
    endtask

    task automatic test_ext();
        sb.push_back({2'b10, 8'h75});
        sb.push_back({2'b11, 8'h75});
        exp_press++;
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        wait_drain("ext");
        check_press("ext");
    endtask

    task automatic test_frame_err();
        send_bits(8'h1C, 1'b1, 11);
        tick(4);
        vectors++;
        if (frame_err !== 1'b1 || fifo_level !== 3'd0) begin
            miscompares++;
            $display("FAIL parity_err: ferr=%b lvl=%0d, required ferr=1 lvl=0", frame_err, fifo_level);
        end
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_clr: ferr=%b, required 0", frame_err);
        end
        sb.push_back({2'b00, 8'h1C});
        exp_press++;
        send_byte(8'h1C);
        wait_drain("parity_recover");
        check_press("parity_recover");
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h16, 8'h1A, 8'h1D, 8'h24};
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                sb.push_back({2'b00, codes[i]});
                exp_press++;
            end
            send_byte(codes[i]);
        end
        tick(4);
        vectors++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_state: lvl=%0d ovf=%b, required lvl=4 ovf=1", fifo_level, overflow);
        end
        check_press("ovf");
        for (int i = 0; i < 3; i++) begin
            tick(1);
            vectors++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 8'h15) begin
                miscompares++;
                $display("FAIL ovf_hold: valid=%b code=%h, required valid=1 code=15",
                         evt_if.evt_valid, evt_if.evt_code);
            end
        end
        evt_if.evt_ready = 1'b1;
        wait_drain("ovf");
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clr: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_timeout();
        send_bits(8'h1B, 1'b0, 6);
        tick(TMO + 20);
        sb.push_back({2'b00, 8'h1B});
        exp_press++;
        send_byte(8'h1B);
        wait_drain("timeout");
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_ferr: ferr=%b, required 0", frame_err);
        end
        check_press("timeout");
    endtask

    task automatic test_reset_mid_frame();
        evt_if.evt_ready = 1'b0;
        send_byte(8'h29);
        send_bits(8'h2A, 1'b0, 5);
        resetn = 1'b0;
        tick(2);
        vectors++;
        if (fifo_level !== 3'd0 || evt_if.evt_valid !== 1'b0 || press_count !== '0) begin
            miscompares++;
            $display("FAIL midreset: lvl=%0d valid=%b cnt=%0d, required all 0",
                     fifo_level, evt_if.evt_valid, press_count);
        end
        resetn = 1'b1;
        exp_press = 0;
        evt_if.evt_ready = 1'b1;
        tick(3);
        sb.push_back({2'b00, 8'h2A});
        exp_press++;
        send_byte(8'h2A);
        wait_drain("midreset");
        check_press("midreset");
    endtask

    task automatic test_typematic();
`ifdef PS2_TYPEMATIC_FILTER_EN
        sb.push_back({2'b00, 8'h1B});
        sb.push_back({2'b01, 8'h1B});
        exp_press += 1;
`else
        sb.push_back({2'b00, 8'h1B});
        sb.push_back({2'b00, 8'h1B});
        sb.push_back({2'b00, 8'h1B});
        sb.push_back({2'b01, 8'h1B});
        exp_press += 3;
`endif
        send_byte(8'h1B);
        send_byte(8'h1B);
        send_byte(8'h1B);
        send_byte(8'hF0);
        send_byte(8'h1B);
        wait_drain("typematic");
        check_press("typematic");
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext();
        test_frame_err();
        test_overflow();
        test_timeout();
        test_reset_mid_frame();
        test_typematic();
        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
